// File: rtl/gate_checker.sv
// Purpose: sweeps all 2**N_IN inputs of a combinational gate and checks its output against EXPECT.
// Latency: each vector takes SETTLE+1 cycles; done/pass rise 2**N_IN*(SETTLE+1) edges after start.
// Backpressure: none; start is ignored while busy, and only reset aborts a running sweep.
module gate_checker #(
  parameter int N_IN = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b0111,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  // settle counter only needs to reach SETTLE-1 before the SAMPLE transition
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // compare the gate output against the truth table bit for the current vector
  always_comb begin
    mismatch = 1'b0;
    err_next = err_count;
    mismatch = (dut_out != EXPECT[dut_in]);
    err_next = err_count + (N_IN+1)'(mismatch);
  end

  // sweep sequencer with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            settle_cnt <= '0;
            dut_in     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_next;
            if (!fail_valid) begin
              first_fail <= dut_in;
              fail_valid <= 1'b1;
            end
          end
          if (dut_in == LAST_VEC) begin
            // dut_in deliberately holds the last vector while results are shown
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            dut_in     <= dut_in + N_IN'(1);
            settle_cnt <= '0;
            state      <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: a 2-input Nand checker and a 1-input Not checker with SETTLE=3.
// Gate models are truth-table lookups so correct, stuck and random faulty gates can be swapped in.
// Expected results come from counting truth-table differences per sweep.
module tb_gate_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // checker A: defaults (Nand, N_IN=2, SETTLE=1)
  logic       a_start, a_out, a_busy, a_done, a_pass, a_fv;
  logic [1:0] a_in, a_ff;
  logic [2:0] a_err;
  logic [3:0] a_tt;
  assign a_out = a_tt[a_in];

  // checker B: Not, N_IN=1, SETTLE=3
  logic       b_start, b_out, b_busy, b_done, b_pass, b_fv;
  logic [0:0] b_in, b_ff;
  logic [1:0] b_err;
  logic [1:0] b_tt;
  assign b_out = b_tt[b_in];

  gate_checker u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .dut_in(a_in), .dut_out(a_out),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .fail_valid(a_fv), .first_fail(a_ff)
  );

  gate_checker #(.N_IN(1), .EXPECT(2'b01), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .dut_in(b_in), .dut_out(b_out),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .fail_valid(b_fv), .first_fail(b_ff)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] o_in, o_busy, o_done, o_pass, o_err, o_fv, o_ff;

  task automatic grab(input int sel);
    if (sel == 0) begin
      o_in = 32'(a_in); o_busy = 32'(a_busy); o_done = 32'(a_done); o_pass = 32'(a_pass);
      o_err = 32'(a_err); o_fv = 32'(a_fv); o_ff = 32'(a_ff);
    end else begin
      o_in = 32'(b_in); o_busy = 32'(b_busy); o_done = 32'(b_done); o_pass = 32'(b_pass);
      o_err = 32'(b_err); o_fv = 32'(b_fv); o_ff = 32'(b_ff);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) a_start = v; else b_start = v;
  endtask

  // One full sweep, called at a negedge. inj >= 0 pulses start again t cycles after acceptance.
  task automatic sweep(input int sel, input logic [3:0] tt, input int inj);
    int n, s, nvec, total, done_vecs, errs, first;
    logic [3:0] ex;
    n     = (sel == 0) ? 2 : 1;
    s     = (sel == 0) ? 1 : 3;
    ex    = (sel == 0) ? 4'b0111 : 4'b0001;
    nvec  = 1 << n;
    total = nvec * (s + 1);
    if (sel == 0) a_tt = tt; else b_tt = tt[1:0];
    set_start(sel, 1'b1);
    for (int t = 0; t <= total; t++) begin
      @(negedge clk);
      set_start(sel, (t == inj));
      // vectors whose compare edge (v+1)(s+1) has already passed
      done_vecs = (t < total) ? t / (s + 1) : nvec;
      errs = 0; first = -1;
      for (int v = 0; v < done_vecs; v++) begin
        if (tt[v] != ex[v]) begin
          errs++;
          if (first < 0) first = v;
        end
      end
      grab(sel);
      check($sformatf("s%0d_t%0d_dut_in", sel, t), o_in, (t < total) ? t / (s + 1) : nvec - 1);
      check($sformatf("s%0d_t%0d_busy", sel, t), o_busy, (t < total) ? 1 : 0);
      check($sformatf("s%0d_t%0d_done", sel, t), o_done, (t == total) ? 1 : 0);
      check($sformatf("s%0d_t%0d_pass", sel, t), o_pass, (t == total && errs == 0) ? 1 : 0);
      check($sformatf("s%0d_t%0d_err", sel, t), o_err, errs);
      check($sformatf("s%0d_t%0d_fv", sel, t), o_fv, (errs > 0) ? 1 : 0);
      check($sformatf("s%0d_t%0d_ff", sel, t), o_ff, (first < 0) ? 0 : first);
    end
    set_start(sel, 1'b0);
  endtask

  task automatic check_idle(input int sel, input string tag);
    grab(sel);
    check({tag, "_dut_in"}, o_in, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_fv"}, o_fv, 0);
    check({tag, "_ff"}, o_ff, 0);
  endtask

  initial begin
    int sel, inj, total;
    logic [3:0] tt;
    rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
    a_tt = 4'b0111; b_tt = 2'b01;
    @(negedge clk); @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "idle_a");

    // correct Nand, stuck-at-1 with ignored mid-sweep start, then restart from DONE
    sweep(0, 4'b0111, -1);
    sweep(0, 4'b1111, 3);
    sweep(0, 4'b0111, -1);
    // And gate against Nand table: every vector fails
    sweep(0, 4'b1000, -1);
    // correct Not on the slow-settle checker, then a stuck-at-0 Not
    sweep(1, 4'b0001, -1);
    sweep(1, 4'b0000, 2);

    // reset during vector 2 must clear everything asynchronously
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    grab(0);
    check("pre_rst_dut_in", o_in, 2);
    #1 rst_n = 1'b0;
    #1 check_idle(0, "async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle(0, "post_rst");
    end

    // randomized gates, mid-sweep start pulses and idle gaps
    for (int i = 0; i < 10; i++) begin
      sel   = int'($urandom_range(0, 1));
      tt    = 4'($urandom);
      total = (sel == 0) ? 8 : 8;
      inj   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, total - 1)) : -1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sweep(sel, tt, inj);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
